// File: rtl/vga_sync_generator.sv
// vga_sync_generator: 640x480 @ 60 Hz VGA timing from a 25 MHz pixel clock.
// Drives the pixel position to the PPU, accepts its 1-bit colour, and delays
// sync/blanking by PIPE_DELAY cycles so they line up with the returned pixel.
// Ports:
//   clk        - pixel clock
//   reset      - asynchronous, active-high reset
//   colour     - PPU pixel (0 black, 1 white)
//   counter_H  - current horizontal pixel, 0..H_TOTAL-1
//   counter_V  - current line, 0..V_TOTAL-1
//   hsync      - horizontal sync, active low
//   vsync      - vertical sync, active low
//   display_on - visible-region flag aligned with rgb_out
//   rgb_out    - {R[1:0],G[1:0],B[1:0]}, forced to 0 while blanking
//   frame_tick - one-cycle pulse while counters show (0, V_VISIBLE)
module vga_sync_generator #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned PIPE_DELAY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       colour,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [5:0] rgb_out,
  output logic       frame_tick
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START   = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END     = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END     = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  // {de, hs, vs} with blanking / both syncs inactive
  localparam logic [2:0] SYNC_IDLE = 3'b011;

  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          h_wrap;
  logic          de_raw;
  logic          hs_raw;
  logic          vs_raw;
  logic [2:0]    sync_raw;
  logic [2:0]    sync_dly;

  // Next counter position; V advances only on the H wrap edge
  always_comb begin
    h_wrap = (counter_H == H_LAST);
    h_next = h_wrap ? '0 : counter_H + 10'd1;
    v_next = counter_V;
    if (h_wrap) begin
      v_next = (counter_V == V_LAST) ? '0 : counter_V + 10'd1;
    end
  end

  // Undelayed decode of the current position
  always_comb begin
    de_raw   = (counter_H < H_VIS_END) && (counter_V < V_VIS_END);
    hs_raw   = !((counter_H >= HS_START) && (counter_H < HS_END));
    vs_raw   = !((counter_V >= VS_START) && (counter_V < VS_END));
    sync_raw = {de_raw, hs_raw, vs_raw};
  end

  // Position counters; frame_tick is registered from the next position so it
  // is high in the same cycle the counters read (0, V_VISIBLE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_H  <= '0;
      counter_V  <= '0;
      frame_tick <= 1'b0;
    end else begin
      counter_H  <= h_next;
      counter_V  <= v_next;
      frame_tick <= (h_next == '0) && (v_next == V_VIS_END);
    end
  end

  // Delay line matching the PPU latency
  generate
    if (PIPE_DELAY == 0) begin : g_bypass
      assign sync_dly = sync_raw;
    end else begin : g_pipe
      logic [2:0] stage [PIPE_DELAY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
            stage[i] <= SYNC_IDLE;
          end
        end else begin
          stage[0] <= sync_raw;
          for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign sync_dly = stage[PIPE_DELAY-1];
    end
  endgenerate

  // Output register; colour is taken in the same cycle as the delayed decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_on <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb_out    <= '0;
    end else begin
      display_on <= sync_dly[2];
      hsync      <= sync_dly[1];
      vsync      <= sync_dly[0];
      rgb_out    <= sync_dly[2] ? {6{colour}} : 6'b000000;
    end
  end

endmodule
